// File: rtl/pcie_rx_8b10b_decoder_if.sv
// Receive-lane symbol/byte bundle: 10b code groups in, decoded bytes and lane status out.
// slave = decoder side, master = symbol source / MAC observer.
interface pcie_rx_8b10b_decoder_if;
    logic [9:0] symbol_i;
    logic       symbol_valid_i;
    logic [7:0] data_o;
    logic       data_k_o;
    logic       data_valid_o;
    logic       code_err_o;
    logic       disp_err_o;
    logic       lock_o;
    logic       rd_o;
    logic [3:0] err_cnt_o;

    modport master (
        output symbol_i, symbol_valid_i,
        input  data_o, data_k_o, data_valid_o, code_err_o, disp_err_o, lock_o, rd_o, err_cnt_o
    );
    modport slave (
        input  symbol_i, symbol_valid_i,
        output data_o, data_k_o, data_valid_o, code_err_o, disp_err_o, lock_o, rd_o, err_cnt_o
    );
endinterface

// File: rtl/pcie_rx_8b10b_decoder.sv
// Per-lane 8b/10b receive decoder: table decode, running-disparity tracking and
// COM-acquire / error-count-loss symbol lock. All outputs registered, 1-cycle latency.
module pcie_rx_8b10b_decoder #(
    parameter int ERR_LIMIT = 4,
    parameter int GOOD_RUN  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    pcie_rx_8b10b_decoder_if.slave        bus
);
    localparam logic [3:0] EL = 4'(ERR_LIMIT);
    localparam logic [7:0] GR = 8'(GOOD_RUN);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;
    typedef struct packed { logic ok; logic [4:0] val; logic k28; } dec6_t;
    typedef struct packed { logic ok; logic [2:0] val; logic p7; logic a7; } dec4_t;

    function automatic dec6_t dec6(input logic [5:0] s);
        dec6_t d;
        d.ok = 1'b1; d.val = 5'd0; d.k28 = 1'b0;
        case (s)
            6'b100111, 6'b011000: d.val = 5'd0;
            6'b011101, 6'b100010: d.val = 5'd1;
            6'b101101, 6'b010010: d.val = 5'd2;
            6'b110001:            d.val = 5'd3;
            6'b110101, 6'b001010: d.val = 5'd4;
            6'b101001:            d.val = 5'd5;
            6'b011001:            d.val = 5'd6;
            6'b111000, 6'b000111: d.val = 5'd7;
            6'b111001, 6'b000110: d.val = 5'd8;
            6'b100101:            d.val = 5'd9;
            6'b010101:            d.val = 5'd10;
            6'b110100:            d.val = 5'd11;
            6'b001101:            d.val = 5'd12;
            6'b101100:            d.val = 5'd13;
            6'b011100:            d.val = 5'd14;
            6'b010111, 6'b101000: d.val = 5'd15;
            6'b011011, 6'b100100: d.val = 5'd16;
            6'b100011:            d.val = 5'd17;
            6'b010011:            d.val = 5'd18;
            6'b110010:            d.val = 5'd19;
            6'b001011:            d.val = 5'd20;
            6'b101010:            d.val = 5'd21;
            6'b011010:            d.val = 5'd22;
            6'b111010, 6'b000101: d.val = 5'd23;
            6'b110011, 6'b001100: d.val = 5'd24;
            6'b100110:            d.val = 5'd25;
            6'b010110:            d.val = 5'd26;
            6'b110110, 6'b001001: d.val = 5'd27;
            6'b001110:            d.val = 5'd28;
            6'b101110, 6'b010001: d.val = 5'd29;
            6'b011110, 6'b100001: d.val = 5'd30;
            6'b101011, 6'b010100: d.val = 5'd31;
            6'b001111, 6'b110000: begin d.val = 5'd28; d.k28 = 1'b1; end
            default:              d.ok = 1'b0;
        endcase
        return d;
    endfunction

    function automatic dec4_t dec4(input logic [3:0] s);
        dec4_t d;
        d.ok = 1'b1; d.val = 3'd0; d.p7 = 1'b0; d.a7 = 1'b0;
        case (s)
            4'b1011, 4'b0100: d.val = 3'd0;
            4'b1001:          d.val = 3'd1;
            4'b0101:          d.val = 3'd2;
            4'b1100, 4'b0011: d.val = 3'd3;
            4'b1101, 4'b0010: d.val = 3'd4;
            4'b1010:          d.val = 3'd5;
            4'b0110:          d.val = 3'd6;
            4'b1110, 4'b0001: begin d.val = 3'd7; d.p7 = 1'b1; end
            4'b0111, 4'b1000: begin d.val = 3'd7; d.a7 = 1'b1; end
            default:          d.ok = 1'b0;
        endcase
        return d;
    endfunction

    state_t     r_state, w_state_nxt;
    logic [7:0] r_data, w_data;
    logic       r_k, w_k, r_dv, w_dv, r_ce, w_ce, r_de, w_de, r_rd;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_good, w_good_nxt;

    logic [5:0] w_s6;
    logic [3:0] w_s4, w_f4;
    dec6_t      w_d6;
    dec4_t      w_d4;
    logic       w_kx7, w_grp17, w_grp11, w_sym_k, w_code_err, w_disp_err;
    logic       w_rd6, w_rd_nxt, w_com, w_err;
    int         w_n6, w_n4;

    assign w_s6 = bus.symbol_i[9:4];
    assign w_s4 = bus.symbol_i[3:0];
    assign w_d6 = dec6(w_s6);
    // The K28 RD+ form is the bitwise complement of the RD- form, so fold it before the 4b lookup.
    assign w_f4 = (w_s6 == 6'b110000) ? ~w_s4 : w_s4;
    assign w_d4 = dec4(w_f4);

    assign w_kx7   = (w_d6.val == 5'd23) || (w_d6.val == 5'd27) || (w_d6.val == 5'd29) || (w_d6.val == 5'd30);
    assign w_grp17 = !w_d6.k28 && ((w_d6.val == 5'd17) || (w_d6.val == 5'd18) || (w_d6.val == 5'd20));
    assign w_grp11 = (w_d6.val == 5'd11) || (w_d6.val == 5'd13) || (w_d6.val == 5'd14);
    assign w_sym_k = w_d6.k28 || (w_d4.a7 && w_kx7);

    // x.7 alternates: K28 needs A7, D17/18/20 only take 0111, D11/13/14 only take 1000.
    assign w_code_err = !w_d6.ok || !w_d4.ok
                     || (w_d6.k28 && w_d4.p7)
                     || (!w_d6.k28 && w_d4.a7 && !w_kx7 && !w_grp17 && !w_grp11)
                     || (w_grp17 && (w_s4 == 4'b1110 || w_s4 == 4'b1000))
                     || (w_grp11 && (w_s4 == 4'b0001 || w_s4 == 4'b0111));

    always_comb begin
        w_n6       = $countones(w_s6);
        w_n4       = $countones(w_s4);
        w_disp_err = 1'b0;
        w_rd6      = r_rd;
        if (w_n6 == 4)                 begin w_disp_err = r_rd;  w_rd6 = 1'b1; end
        else if (w_n6 == 2)            begin w_disp_err = !r_rd; w_rd6 = 1'b0; end
        else if (w_s6 == 6'b111000)    w_disp_err = r_rd;
        else if (w_s6 == 6'b000111)    w_disp_err = !r_rd;
        w_rd_nxt = w_rd6;
        if (w_n4 == 3)                 begin w_disp_err = w_disp_err | w_rd6;  w_rd_nxt = 1'b1; end
        else if (w_n4 == 1)            begin w_disp_err = w_disp_err | !w_rd6; w_rd_nxt = 1'b0; end
        else if (w_s4 == 4'b1100)      w_disp_err = w_disp_err | w_rd6;
        else if (w_s4 == 4'b0011)      w_disp_err = w_disp_err | !w_rd6;
    end

    assign w_com = (bus.symbol_i == 10'h0FA) || (bus.symbol_i == 10'h305);
    assign w_err = w_code_err || w_disp_err;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) r_state <= UNLOCKED;
        else       r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_good_nxt  = r_good;
        if (bus.symbol_valid_i) begin
            if (r_state == UNLOCKED) begin
                w_cnt_nxt  = 4'd0;
                w_good_nxt = 8'd0;
                if (w_com) w_state_nxt = LOCKED;
            end else if (w_err) begin
                w_good_nxt = 8'd0;
                w_cnt_nxt  = (r_cnt >= EL) ? EL : r_cnt + 4'd1;
                if (w_cnt_nxt >= EL) w_state_nxt = UNLOCKED;
            end else if (r_good + 8'd1 >= GR) begin
                w_good_nxt = 8'd0;
                w_cnt_nxt  = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
            end else begin
                w_good_nxt = r_good + 8'd1;
            end
        end
    end

    always_comb begin
        w_dv = 1'b0; w_data = 8'h00; w_k = 1'b0; w_ce = 1'b0; w_de = 1'b0;
        if (bus.symbol_valid_i) begin
            if (r_state == LOCKED) begin
                w_dv = 1'b1;
                w_ce = w_code_err;
                w_de = w_disp_err;
                if (!w_code_err) begin
                    w_data = {w_d4.val, w_d6.val};
                    w_k    = w_sym_k;
                end
            end else if (w_com) begin
                w_dv = 1'b1; w_data = 8'hBC; w_k = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            r_dv <= 1'b0; r_data <= 8'h00; r_k <= 1'b0; r_ce <= 1'b0; r_de <= 1'b0;
            r_rd <= 1'b0; r_cnt <= 4'd0; r_good <= 8'd0;
        end else begin
            r_dv <= w_dv; r_data <= w_data; r_k <= w_k; r_ce <= w_ce; r_de <= w_de;
            if (bus.symbol_valid_i) r_rd <= w_rd_nxt;
            r_cnt  <= w_cnt_nxt;
            r_good <= w_good_nxt;
        end

    assign bus.data_o       = r_data;
    assign bus.data_k_o     = r_k;
    assign bus.data_valid_o = r_dv;
    assign bus.code_err_o   = r_ce;
    assign bus.disp_err_o   = r_de;
    assign bus.lock_o       = (r_state == LOCKED);
    assign bus.rd_o         = r_rd;
    assign bus.err_cnt_o    = r_cnt;
endmodule

// File: tb/tb_pcie_rx_8b10b_decoder.sv
// Directed bench for the 8b/10b receive decoder: lock acquire/loss, RD tracking,
// error counting/recovery, K/A7 decode and asynchronous reset.
module tb_pcie_rx_8b10b_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    pcie_rx_8b10b_decoder_if bus();

    pcie_rx_8b10b_decoder #(.ERR_LIMIT(4), .GOOD_RUN(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [9:0] s);
        @(negedge clk);
        bus.symbol_i       = s;
        bus.symbol_valid_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.symbol_valid_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] v;
        #12;
        v = {bus.data_o, bus.data_k_o, bus.data_valid_o, bus.code_err_o, bus.disp_err_o,
             bus.lock_o, bus.rd_o, bus.err_cnt_o};
        total++; if (v !== 18'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", v); end
        @(negedge clk); rst = 1'b0;
        idle();
        v = {bus.data_o, bus.data_k_o, bus.data_valid_o, bus.code_err_o, bus.disp_err_o,
             bus.lock_o, bus.rd_o, bus.err_cnt_o};
        total++; if (v !== 18'd0) begin bad++; $display("FAIL idle_outputs got=%h want=0", v); end
    endtask

    task automatic test_unlocked_ignore();
        drive(10'h2AA);
        total++; if ({bus.data_valid_o, bus.code_err_o, bus.disp_err_o, bus.lock_o} !== 4'b0000) begin
            bad++; $display("FAIL unlocked_data got=%b want=0000", {bus.data_valid_o, bus.code_err_o, bus.disp_err_o, bus.lock_o}); end
        drive(10'h000);
        total++; if ({bus.data_valid_o, bus.code_err_o, bus.disp_err_o, bus.err_cnt_o} !== 7'd0) begin
            bad++; $display("FAIL unlocked_err_hidden got=%b want=0", {bus.data_valid_o, bus.code_err_o, bus.disp_err_o, bus.err_cnt_o}); end
    endtask

    task automatic test_lock_rdplus();
        drive(10'h0FA);
        total++; if ({bus.data_o, bus.data_k_o, bus.data_valid_o} !== {8'hBC, 1'b1, 1'b1}) begin
            bad++; $display("FAIL com_plus_data got=%h/%b/%b want=bc/1/1", bus.data_o, bus.data_k_o, bus.data_valid_o); end
        total++; if ({bus.lock_o, bus.rd_o} !== 2'b11) begin
            bad++; $display("FAIL com_plus_lock_rd got=%b want=11", {bus.lock_o, bus.rd_o}); end
        drive(10'h18B);
        total++; if ({bus.data_o, bus.data_k_o, bus.data_valid_o, bus.code_err_o, bus.disp_err_o, bus.rd_o} !== {8'h00, 5'b01001}) begin
            bad++; $display("FAIL d0_0_rdplus got=%h %b want=00 01001", bus.data_o, {bus.data_k_o, bus.data_valid_o, bus.code_err_o, bus.disp_err_o, bus.rd_o}); end
    endtask

    task automatic test_disp_err_recovery();
        drive(10'h274);
        total++; if ({bus.disp_err_o, bus.code_err_o, bus.data_valid_o} !== 3'b101) begin
            bad++; $display("FAIL disp_err_flags got=%b want=101", {bus.disp_err_o, bus.code_err_o, bus.data_valid_o}); end
        total++; if ({bus.data_o, bus.err_cnt_o, bus.rd_o} !== {8'h00, 4'd1, 1'b0}) begin
            bad++; $display("FAIL disp_err_state got=%h/%0d/%b want=00/1/0", bus.data_o, bus.err_cnt_o, bus.rd_o); end
        for (int i = 0; i < 15; i++) drive(10'h2AA);
        total++; if ({bus.data_o, bus.err_cnt_o, bus.disp_err_o} !== {8'hB5, 4'd1, 1'b0}) begin
            bad++; $display("FAIL good_run_15 got=%h/%0d/%b want=b5/1/0", bus.data_o, bus.err_cnt_o, bus.disp_err_o); end
        drive(10'h2AA);
        total++; if (bus.err_cnt_o !== 4'd0) begin
            bad++; $display("FAIL good_run_16 got=%0d want=0", bus.err_cnt_o); end
    endtask

    task automatic test_k_and_alt7();
        drive(10'h0F9);   // K28.1 at RD-
        total++; if ({bus.data_o, bus.data_k_o, bus.code_err_o, bus.disp_err_o, bus.rd_o} !== {8'h3C, 4'b1001}) begin
            bad++; $display("FAIL k28_1 got=%h %b want=3c 1001", bus.data_o, {bus.data_k_o, bus.code_err_o, bus.disp_err_o, bus.rd_o}); end
        drive(10'h057);   // K23.7 at RD+
        total++; if ({bus.data_o, bus.data_k_o, bus.code_err_o, bus.disp_err_o, bus.rd_o} !== {8'hF7, 4'b1001}) begin
            bad++; $display("FAIL k23_7 got=%h %b want=f7 1001", bus.data_o, {bus.data_k_o, bus.code_err_o, bus.disp_err_o, bus.rd_o}); end
        drive(10'h348);   // D11.A7 at RD+
        total++; if ({bus.data_o, bus.data_k_o, bus.code_err_o, bus.disp_err_o, bus.rd_o} !== {8'hEB, 4'b0000}) begin
            bad++; $display("FAIL d11_a7 got=%h %b want=eb 0000", bus.data_o, {bus.data_k_o, bus.code_err_o, bus.disp_err_o, bus.rd_o}); end
        drive(10'h237);   // D17.A7 at RD-
        total++; if ({bus.data_o, bus.data_k_o, bus.code_err_o, bus.disp_err_o, bus.rd_o} !== {8'hF1, 4'b0001}) begin
            bad++; $display("FAIL d17_a7 got=%h %b want=f1 0001", bus.data_o, {bus.data_k_o, bus.code_err_o, bus.disp_err_o, bus.rd_o}); end
    endtask

    task automatic test_lock_loss();
        logic [3:0] exp_cnt;
        for (int i = 1; i <= 4; i++) begin
            drive(10'h000);
            exp_cnt = 4'(i);
            total++; if ({bus.code_err_o, bus.disp_err_o, bus.data_valid_o, bus.data_o} !== {3'b101, 8'h00}) begin
                bad++; $display("FAIL loss_flags_%0d got=%b/%h want=101/00", i, {bus.code_err_o, bus.disp_err_o, bus.data_valid_o}, bus.data_o); end
            total++; if ({bus.err_cnt_o, bus.lock_o} !== {exp_cnt, (i < 4)}) begin
                bad++; $display("FAIL loss_cnt_%0d got=%0d/%b want=%0d/%b", i, bus.err_cnt_o, bus.lock_o, exp_cnt, (i < 4)); end
        end
        drive(10'h2AA);
        total++; if ({bus.data_valid_o, bus.code_err_o, bus.lock_o, bus.err_cnt_o} !== 7'd0) begin
            bad++; $display("FAIL after_loss got=%b want=0", {bus.data_valid_o, bus.code_err_o, bus.lock_o, bus.err_cnt_o}); end
    endtask

    task automatic test_relock_rdminus_idle();
        drive(10'h305);
        total++; if ({bus.data_o, bus.data_k_o, bus.data_valid_o, bus.lock_o, bus.rd_o} !== {8'hBC, 4'b1110}) begin
            bad++; $display("FAIL com_minus got=%h %b want=bc 1110", bus.data_o, {bus.data_k_o, bus.data_valid_o, bus.lock_o, bus.rd_o}); end
        for (int i = 0; i < 3; i++) begin
            idle();
            total++; if ({bus.data_valid_o, bus.code_err_o, bus.disp_err_o, bus.lock_o, bus.rd_o, bus.err_cnt_o} !== {5'b00010, 4'd0}) begin
                bad++; $display("FAIL idle_hold_%0d got=%b want=000100000", i, {bus.data_valid_o, bus.code_err_o, bus.disp_err_o, bus.lock_o, bus.rd_o, bus.err_cnt_o}); end
        end
    endtask

    task automatic test_async_reset();
        logic [17:0] v;
        drive(10'h000);
        drive(10'h000);
        total++; if ({bus.err_cnt_o, bus.lock_o} !== {4'd2, 1'b1}) begin
            bad++; $display("FAIL pre_reset_cnt got=%0d/%b want=2/1", bus.err_cnt_o, bus.lock_o); end
        rst = 1'b1;
        #2;
        v = {bus.data_o, bus.data_k_o, bus.data_valid_o, bus.code_err_o, bus.disp_err_o,
             bus.lock_o, bus.rd_o, bus.err_cnt_o};
        total++; if (v !== 18'd0) begin bad++; $display("FAIL async_reset got=%h want=0", v); end
        @(negedge clk); rst = 1'b0;
        drive(10'h0FA);
        total++; if ({bus.data_o, bus.lock_o, bus.rd_o, bus.err_cnt_o} !== {8'hBC, 2'b11, 4'd0}) begin
            bad++; $display("FAIL relock_after_reset got=%h %b %0d want=bc 11 0", bus.data_o, {bus.lock_o, bus.rd_o}, bus.err_cnt_o); end
    endtask

    task automatic test_back_to_back();
        drive(10'h18B);   // D0.0 at RD+, RD stays +
        drive(10'h38A);   // D7.5 with 111000 alternate at RD+: disparity violation
        total++; if ({bus.data_o, bus.disp_err_o, bus.code_err_o, bus.rd_o, bus.err_cnt_o} !== {8'hA7, 3'b101, 4'd1}) begin
            bad++; $display("FAIL d7_alt_rdplus got=%h %b %0d want=a7 101 1", bus.data_o, {bus.disp_err_o, bus.code_err_o, bus.rd_o}, bus.err_cnt_o); end
        drive(10'h0FA);   // COM while locked at RD+: counted disparity error, RD not re-seeded
        total++; if ({bus.data_o, bus.data_k_o, bus.disp_err_o, bus.rd_o, bus.err_cnt_o, bus.lock_o} !== {8'hBC, 3'b111, 4'd2, 1'b1}) begin
            bad++; $display("FAIL com_locked_rdplus got=%h %b %0d want=bc 111 2", bus.data_o, {bus.data_k_o, bus.disp_err_o, bus.rd_o}, bus.err_cnt_o); end
    endtask

    initial begin
        bus.symbol_i       = 10'h000;
        bus.symbol_valid_i = 1'b0;
        test_reset();
        test_unlocked_ignore();
        test_lock_rdplus();
        test_disp_err_recovery();
        test_k_and_alt7();
        test_lock_loss();
        test_relock_rdminus_idle();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
